mult_block_scheduler: RTL and testbench

- Sits in front of the multiplier/buffer block and shares it between two requesters.
- Grants one whole buffer block (DEPTH = 2^LOGDEPTH products) to one requester at a time, using round-robin.
- Sequences the block as follows: feed DEPTH operand pairs, wait for the datapath to flush, issue EN_blockRead, then return the DEPTH results tagged with the owner ID.

---
 rtl/mult_block_scheduler.sv | 175 +++++++++++++++++
 tb/tb_mult_block_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mult_block_scheduler.sv
// Round-robin scheduler granting the shared multiplier/buffer block to one of two requesters per block.
// Optional per-requester block counters and a stall counter are enabled with MULT_SCHED_STATS_EN.
module mult_block_scheduler #(
    parameter int LOGDEPTH     = 6,
    parameter int WIDTH        = 16,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [15:0]      req0_a,
    input  logic [15:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [15:0]      req1_a,
    input  logic [15:0]      req1_b,
    output logic             req1_ready,
    output logic             EN_mult,
    output logic [15:0]      mult_input0,
    output logic [15:0]      mult_input1,
    input  logic             RDY_mult,
    output logic             EN_blockRead,
    input  logic             VALID_memVal,
    input  logic [WIDTH-1:0] memVal_data,
    output logic             res_valid,
    output logic [WIDTH-1:0] res_data,
    output logic             res_owner,
    output logic             busy
`ifdef MULT_SCHED_STATS_EN
    ,
    output logic [15:0]      blk_cnt0,
    output logic [15:0]      blk_cnt1,
    output logic [15:0]      stall_cnt
`endif
);

    localparam int DEPTH = 1 << LOGDEPTH;
    localparam logic [LOGDEPTH:0] CNT_FULL = (LOGDEPTH+1)'(DEPTH);
    localparam logic [LOGDEPTH:0] CNT_LAST = (LOGDEPTH+1)'(DEPTH - 1);
    localparam logic [3:0]        FLUSH_LAST = 4'(FLUSH_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, FILL, FLUSH, READ_REQ, DRAIN} state_t;

    state_t            state, state_nxt;
    logic              prio, prio_nxt;
    logic              owner, owner_nxt;
    logic [LOGDEPTH:0] issue_cnt, issue_nxt;
    logic [LOGDEPTH:0] beat_cnt, beat_nxt;
    logic [3:0]        flush_cnt, flush_nxt;
    logic              own_valid, fire, beat, blk_done;

    logic              vld_p0;
    logic              owner_p0;
    logic [WIDTH-1:0]  data_p0;

    always_comb begin
        own_valid = owner ? req1_valid : req0_valid;
        fire      = (state == FILL) && own_valid && RDY_mult;
        beat      = (state == DRAIN) && VALID_memVal;
        blk_done  = beat && (beat_cnt == CNT_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            prio      <= 1'b0;
            owner     <= 1'b0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
        end else begin
            state     <= state_nxt;
            prio      <= prio_nxt;
            owner     <= owner_nxt;
            issue_cnt <= issue_nxt;
            beat_cnt  <= beat_nxt;
            flush_cnt <= flush_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        prio_nxt  = prio;
        owner_nxt = owner;
        issue_nxt = issue_cnt;
        beat_nxt  = beat_cnt;
        flush_nxt = flush_cnt;
        unique case (state)
            IDLE: begin
                if (req0_valid || req1_valid) begin
                    // Contention is resolved by prio; a lone requester always wins.
                    owner_nxt = (req0_valid && req1_valid) ? prio : req1_valid;
                    issue_nxt = '0;
                    state_nxt = FILL;
                end
            end
            FILL: begin
                if (fire) begin
                    issue_nxt = (issue_cnt == CNT_FULL) ? issue_cnt : issue_cnt + 1'b1;
                    if (issue_cnt == CNT_LAST) begin
                        flush_nxt = '0;
                        state_nxt = FLUSH;
                    end
                end
            end
            FLUSH: begin
                if (flush_cnt == FLUSH_LAST) begin
                    state_nxt = READ_REQ;
                end else begin
                    flush_nxt = flush_cnt + 1'b1;
                end
            end
            READ_REQ: begin
                beat_nxt  = '0;
                state_nxt = DRAIN;
            end
            DRAIN: begin
                if (beat) begin
                    beat_nxt = (beat_cnt == CNT_FULL) ? beat_cnt : beat_cnt + 1'b1;
                end
                if (blk_done) begin
                    prio_nxt  = ~prio;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        EN_mult      = fire;
        req0_ready   = fire && !owner;
        req1_ready   = fire && owner;
        mult_input0  = (state == FILL) ? (owner ? req1_a : req0_a) : 16'h0;
        mult_input1  = (state == FILL) ? (owner ? req1_b : req0_b) : 16'h0;
        EN_blockRead = (state == READ_REQ);
        busy         = (state != IDLE);
    end

    // Stage p0: read beats registered on their way to the result port.
    always_ff @(posedge clk) begin
        if (!rst) begin
            vld_p0   <= 1'b0;
            owner_p0 <= 1'b0;
            data_p0  <= '0;
        end else begin
            vld_p0 <= beat;
            if (beat) begin
                owner_p0 <= owner;
                data_p0  <= memVal_data;
            end
        end
    end

    assign res_valid = vld_p0;
    assign res_data  = data_p0;
    assign res_owner = owner_p0;

`ifdef MULT_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            blk_cnt0  <= 16'h0;
            blk_cnt1  <= 16'h0;
            stall_cnt <= 16'h0;
        end else begin
            if (blk_done && !owner) blk_cnt0 <= blk_cnt0 + 16'h1;
            if (blk_done && owner)  blk_cnt1 <= blk_cnt1 + 16'h1;
            if ((state == FILL) && own_valid && !RDY_mult && (stall_cnt != 16'hFFFF)) begin
                stall_cnt <= stall_cnt + 16'h1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_mult_block_scheduler.sv
// Randomized bench for mult_block_scheduler; the bench plays both requesters and the multiplier memory.
module tb_mult_block_scheduler;
    localparam int LOGDEPTH     = 6;
    localparam int DEPTH        = 64;
    localparam int WIDTH        = 16;
    localparam int FLUSH_CYCLES = 4;
    localparam int BUDGET       = 2000;

    logic             clk;
    logic             rst;
    logic             req0_valid, req1_valid;
    logic [15:0]      req0_a, req0_b, req1_a, req1_b;
    logic             req0_ready, req1_ready;
    logic             EN_mult;
    logic [15:0]      mult_input0, mult_input1;
    logic             RDY_mult;
    logic             EN_blockRead;
    logic             VALID_memVal;
    logic [WIDTH-1:0] memVal_data;
    logic             res_valid;
    logic [WIDTH-1:0] res_data;
    logic             res_owner;
    logic             busy;
`ifdef MULT_SCHED_STATS_EN
    logic [15:0]      blk_cnt0, blk_cnt1, stall_cnt;
`endif

    int checks = 0;
    int errors = 0;
    int prio_m = 0;
    int blk_m0 = 0;
    int blk_m1 = 0;
    int stall_m = 0;

    mult_block_scheduler #(
        .LOGDEPTH(LOGDEPTH), .WIDTH(WIDTH), .FLUSH_CYCLES(FLUSH_CYCLES)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .EN_mult(EN_mult), .mult_input0(mult_input0), .mult_input1(mult_input1),
        .RDY_mult(RDY_mult), .EN_blockRead(EN_blockRead),
        .VALID_memVal(VALID_memVal), .memVal_data(memVal_data),
        .res_valid(res_valid), .res_data(res_data), .res_owner(res_owner), .busy(busy)
`ifdef MULT_SCHED_STATS_EN
        , .blk_cnt0(blk_cnt0), .blk_cnt1(blk_cnt1), .stall_cnt(stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_outs"}, {req0_ready, req1_ready, EN_mult, EN_blockRead, res_valid, res_owner, busy}, 0);
        check_eq({tag, "_data"}, {mult_input0, mult_input1, res_data}, 0);
    endtask

    // Drive the owner's pair and a random pair on the other requester.
    task automatic drive_req(input int own, input bit ovalid, input bit other_valid,
                             input logic [15:0] a, input logic [15:0] b);
        if (own == 0) begin
            req0_valid = ovalid; req0_a = a; req0_b = b;
            req1_valid = other_valid; req1_a = 16'($urandom); req1_b = 16'($urandom);
        end else begin
            req1_valid = ovalid; req1_a = a; req1_b = b;
            req0_valid = other_valid; req0_a = 16'($urandom); req0_b = 16'($urandom);
        end
    endtask

    // mode 0: RDY_mult steady, a=i b=2; 1: RDY toggles + 3-cycle owner drop; 2: random RDY
    task automatic do_block(input bit v0, input bit v1, input int mode);
        logic [15:0] a_arr[DEPTH];
        logic [15:0] b_arr[DEPTH];
        logic [15:0] prod;
        logic [15:0] prev_d;
        logic        prev_v, rdy, ovalid, mv;
        bit          other_v;
        int          own, fires, cyc, drop_cnt, gap, beats;
        own = (v0 && v1) ? prio_m : (v1 ? 1 : 0);
        other_v = (own == 0) ? v1 : v0;
        for (int i = 0; i < DEPTH; i++) begin
            a_arr[i] = (mode == 0) ? 16'(i) : 16'($urandom);
            b_arr[i] = (mode == 0) ? 16'd2 : 16'($urandom);
        end
        // IDLE cycle: grant decided, nothing accepted yet
        @(posedge clk); #1;
        drive_req(own, 1'b1, other_v, a_arr[0], b_arr[0]);
        RDY_mult = 1'b1;
        @(negedge clk);
        check_eq("idle_en_mult", EN_mult, 0);
        check_eq("idle_ready", {req0_ready, req1_ready}, 0);
        check_eq("idle_busy", busy, 0);

        fires = 0; cyc = 0; drop_cnt = 0;
        while (fires < DEPTH && cyc < BUDGET) begin
            @(posedge clk); #1;
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = cyc[0];
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            ovalid = 1'b1;
            if (mode == 1 && fires >= 30 && drop_cnt < 3) begin
                ovalid = 1'b0;
                drop_cnt++;
            end
            RDY_mult = rdy;
            drive_req(own, ovalid, other_v, a_arr[fires], b_arr[fires]);
            @(negedge clk);
            check_eq("fill_busy", busy, 1);
            check_eq("fill_en_mult", EN_mult, ovalid & rdy);
            check_eq("fill_own_ready", (own == 0) ? req0_ready : req1_ready, ovalid & rdy);
            check_eq("fill_other_ready", (own == 0) ? req1_ready : req0_ready, 0);
            if (ovalid && !rdy) stall_m++;
            if (ovalid && rdy) begin
                check_eq("fill_in0", mult_input0, a_arr[fires]);
                check_eq("fill_in1", mult_input1, b_arr[fires]);
                fires++;
            end
            cyc++;
        end
        if (cyc >= BUDGET) check_eq("fill_timeout", fires, DEPTH);

        // Flush: count quiet cycles until the block read request
        gap = 0;
        forever begin
            @(posedge clk); #1;
            drive_req(own, 1'b0, other_v, 16'h0, 16'h0);
            RDY_mult = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (EN_blockRead === 1'b1 || gap >= 20) break;
            check_eq("flush_en_mult", EN_mult, 0);
            gap++;
        end
        check_eq("flush_gap", gap, FLUSH_CYCLES);
        check_eq("read_req_busy", busy, 1);

        // Drain: bench acts as memory holding the products of the accepted pairs
        beats = 0; cyc = 0; prev_v = 1'b0; prev_d = '0;
        while (beats < DEPTH && cyc < BUDGET) begin
            @(posedge clk); #1;
            req0_valid = 1'b0; req1_valid = 1'b0;
            mv = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            prod = a_arr[beats] * b_arr[beats];
            VALID_memVal = mv;
            memVal_data = mv ? prod : 16'($urandom);
            @(negedge clk);
            if (cyc == 0) check_eq("read_req_pulse", EN_blockRead, 0);
            check_eq("drain_busy", busy, 1);
            check_eq("drain_res_valid", res_valid, prev_v);
            if (prev_v) begin
                check_eq("drain_res_data", res_data, prev_d);
                check_eq("drain_res_owner", res_owner, own);
            end
            prev_v = mv;
            prev_d = prod;
            if (mv) beats++;
            cyc++;
        end
        if (cyc >= BUDGET) check_eq("drain_timeout", beats, DEPTH);

        // Last beat surfaces with busy already low; an extra beat in IDLE is ignored
        @(posedge clk); #1;
        VALID_memVal = 1'b1;
        memVal_data = 16'($urandom);
        @(negedge clk);
        check_eq("last_res_valid", res_valid, 1);
        check_eq("last_res_data", res_data, prev_d);
        check_eq("last_res_owner", res_owner, own);
        check_eq("done_busy", busy, 0);
        @(posedge clk); #1;
        VALID_memVal = 1'b0;
        @(negedge clk);
        check_eq("extra_beat_ignored", res_valid, 0);

        prio_m = 1 - prio_m;
        if (own == 0) blk_m0++; else blk_m1++;
    endtask

    initial begin
        rst = 1'b0;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        RDY_mult = 1'b0; VALID_memVal = 1'b0; memVal_data = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        do_block(1'b1, 1'b0, 0);   // lone req0, streaming a=i b=2
        do_block(1'b1, 1'b1, 0);   // contention, prio now 1
        do_block(1'b1, 1'b1, 2);   // contention, prio back to 0
        do_block(1'b0, 1'b1, 1);   // lone req1 with backpressure and valid drop
        do_block(1'b1, 1'b0, 2);   // lone req0 again

        // Reset after 20 accepted pairs of a req1 block
        @(posedge clk); #1;
        drive_req(1, 1'b1, 1'b0, 16'h0, 16'h0);
        RDY_mult = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            req1_a = 16'(i + 100); req1_b = 16'(i);
            @(negedge clk);
            check_eq("pre_reset_fire", {EN_mult, req1_ready}, 2'b11);
            check_eq("pre_reset_in0", mult_input0, 16'(i + 100));
        end
        @(posedge clk); #1;
        rst = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("after_reset");
        prio_m = 0; blk_m0 = 0; blk_m1 = 0; stall_m = 0;

        do_block(1'b1, 1'b1, 1);   // prio restarted at 0
        do_block(1'b1, 1'b1, 0);

`ifdef MULT_SCHED_STATS_EN
        check_eq("blk_cnt0", blk_cnt0, 32'(blk_m0));
        check_eq("blk_cnt1", blk_cnt1, 32'(blk_m1));
        check_eq("stall_cnt", stall_cnt, 32'(stall_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
